// File: rtl/bwt_req_arbiter.sv
// Round-robin arbiter sharing the paired BWT k/l occurrence-line read path among SMEM lanes.
// An in-order tag FIFO routes each returning k/l line pair to the lane that issued it.
module bwt_req_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 2,
    parameter int MAX_OUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic                   CLK_200M,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic                   stall,
    input  logic [57:0]            bwt_base,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*32-1:0]  req_addr_k,
    input  logic [NUM_REQ*32-1:0]  req_addr_l,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   out_valid,
    output logic [57:0]            out_addr_k,
    output logic [57:0]            out_addr_l,
    input  logic                   resp_valid,
    input  logic [511:0]           resp_cl_k,
    input  logic [511:0]           resp_cl_l,
    output logic [NUM_REQ-1:0]     get_valid,
    output logic [511:0]           get_cl_k,
    output logic [511:0]           get_cl_l,
    output logic [CNT_W-1:0]       outstanding,
    output logic                   idle,
    output logic                   resp_error
);

    localparam int                PTR_W     = $clog2(MAX_OUT);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(MAX_OUT);
    localparam logic [TAG_W:0]    NUM_W     = (TAG_W+1)'(NUM_REQ);
    localparam logic [TAG_W-1:0]  LAST_LANE = TAG_W'(NUM_REQ-1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;
    state_t state;

    logic [TAG_W-1:0] rr_ptr;
    logic [TAG_W-1:0] winner;
    logic [TAG_W:0]   cand;
    logic             found;
    logic             can_grant;
    logic             grant;
    logic             pop;
    logic [31:0]      lane_k [NUM_REQ];
    logic [31:0]      lane_l [NUM_REQ];
    logic [TAG_W-1:0] tag_mem [MAX_OUT];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        assign lane_k[i] = req_addr_k[32*i +: 32];
        assign lane_l[i] = req_addr_l[32*i +: 32];
    end

    // Search from rr_ptr upward, wrapping at NUM_REQ; first requesting lane wins.
    always_comb begin
        found  = 1'b0;
        winner = rr_ptr;
        cand   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (TAG_W+1)'(k);
            if (cand >= NUM_W) cand = cand - NUM_W;
            if (!found && req_valid[cand[TAG_W-1:0]]) begin
                found  = 1'b1;
                winner = cand[TAG_W-1:0];
            end
        end
    end

    // A full FIFO blocks grants even when a pop frees a slot this cycle.
    assign can_grant = (state == ST_RUN) && !stall && (outstanding != FULL_CNT);
    assign grant     = can_grant && found;
    assign req_ready = grant ? (NUM_REQ'(1) << winner) : '0;
    assign pop       = resp_valid && (outstanding != '0);
    assign idle      = (state == ST_IDLE);

    always_ff @(posedge CLK_200M or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (enable) state <= ST_RUN;
                ST_RUN:   if (!enable) state <= ST_DRAIN;
                ST_DRAIN: if ((outstanding == '0) && !pop) state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK_200M or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr      <= '0;
            out_valid   <= 1'b0;
            out_addr_k  <= '0;
            out_addr_l  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            outstanding <= '0;
            get_valid   <= '0;
            get_cl_k    <= '0;
            get_cl_l    <= '0;
            resp_error  <= 1'b0;
        end else begin
            out_valid <= grant;
            if (grant) begin
                rr_ptr     <= (winner == LAST_LANE) ? '0 : winner + 1'b1;
                out_addr_k <= bwt_base + {30'd0, lane_k[winner][31:4]};
                out_addr_l <= bwt_base + {30'd0, lane_l[winner][31:4]};
                wr_ptr     <= wr_ptr + 1'b1;
            end

            get_valid <= '0;
            if (pop) begin
                get_valid <= NUM_REQ'(1) << tag_mem[rd_ptr];
                get_cl_k  <= resp_cl_k;
                get_cl_l  <= resp_cl_l;
                rd_ptr    <= rd_ptr + 1'b1;
            end

            // A response with nothing outstanding is dropped and flagged until reset.
            if (resp_valid && (outstanding == '0)) resp_error <= 1'b1;

            case ({grant, pop})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    always_ff @(posedge CLK_200M) begin
        if (grant) tag_mem[wr_ptr] <= winner;
    end

endmodule

// File: tb/tb_bwt_req_arbiter.sv
// Self-checking bench for bwt_req_arbiter: scenario tasks with inline checks plus a
// scoreboard that predicts issued addresses and routed responses from the bench's own stimulus.
module tb_bwt_req_arbiter;

    localparam int NUM_REQ = 4;
    localparam int TAG_W   = 2;
    localparam int MAX_OUT = 16;
    localparam int CNT_W   = 5;

    logic                  clk;
    logic                  reset_n;
    logic                  enable;
    logic                  stall;
    logic [57:0]           bwt_base;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*32-1:0] req_addr_k;
    logic [NUM_REQ*32-1:0] req_addr_l;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  out_valid;
    logic [57:0]           out_addr_k;
    logic [57:0]           out_addr_l;
    logic                  resp_valid;
    logic [511:0]          resp_cl_k;
    logic [511:0]          resp_cl_l;
    logic [NUM_REQ-1:0]    get_valid;
    logic [511:0]          get_cl_k;
    logic [511:0]          get_cl_l;
    logic [CNT_W-1:0]      outstanding;
    logic                  idle;
    logic                  resp_error;

    int checks   = 0;
    int failures = 0;

    bwt_req_arbiter #(
        .NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .MAX_OUT(MAX_OUT), .CNT_W(CNT_W)
    ) dut (
        .CLK_200M(clk), .reset_n(reset_n), .enable(enable), .stall(stall),
        .bwt_base(bwt_base), .req_valid(req_valid), .req_addr_k(req_addr_k),
        .req_addr_l(req_addr_l), .req_ready(req_ready), .out_valid(out_valid),
        .out_addr_k(out_addr_k), .out_addr_l(out_addr_l), .resp_valid(resp_valid),
        .resp_cl_k(resp_cl_k), .resp_cl_l(resp_cl_l), .get_valid(get_valid),
        .get_cl_k(get_cl_k), .get_cl_l(get_cl_l), .outstanding(outstanding),
        .idle(idle), .resp_error(resp_error)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [115:0]           exp_addr_q[$];
    logic [TAG_W-1:0]       tag_q[$];
    logic [NUM_REQ+1023:0]  exp_get_q[$];
    bit                     issue_due;
    bit                     get_due;
    logic [115:0]           sb_addr;
    logic [NUM_REQ+1023:0]  sb_get;
    logic [TAG_W-1:0]       sb_tag;
    int                     sb_lane;

    always @(negedge clk) begin
        if (!reset_n) begin
            exp_addr_q.delete();
            tag_q.delete();
            exp_get_q.delete();
            issue_due = 1'b0;
            get_due   = 1'b0;
        end else begin
            checks++;
            if (issue_due) begin
                sb_addr = exp_addr_q.pop_front();
                if (out_valid !== 1'b1 || out_addr_k !== sb_addr[115:58] || out_addr_l !== sb_addr[57:0]) begin
                    failures++;
                    $display("FAIL sb_issue got v=%b k=%h l=%h exp v=1 k=%h l=%h",
                             out_valid, out_addr_k, out_addr_l, sb_addr[115:58], sb_addr[57:0]);
                end
            end else if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL sb_no_issue got out_valid=%b exp 0", out_valid);
            end

            checks++;
            if (get_due) begin
                sb_get = exp_get_q.pop_front();
                if (get_valid !== sb_get[NUM_REQ+1023:1024] || get_cl_k !== sb_get[1023:512]) begin
                    failures++;
                    $display("FAIL sb_get_k got gv=%b k=%h exp gv=%b k=%h",
                             get_valid, get_cl_k, sb_get[NUM_REQ+1023:1024], sb_get[1023:512]);
                end
                checks++;
                if (get_cl_l !== sb_get[511:0]) begin
                    failures++;
                    $display("FAIL sb_get_l got %h exp %h", get_cl_l, sb_get[511:0]);
                end
            end else if (get_valid !== '0) begin
                failures++;
                $display("FAIL sb_no_get got get_valid=%b exp 0", get_valid);
            end

            checks++;
            if (((req_ready & ~req_valid) != '0) || ($countones(req_ready) > 1)) begin
                failures++;
                $display("FAIL sb_ready_onehot got ready=%b valid=%b", req_ready, req_valid);
            end

            issue_due = 1'b0;
            get_due   = 1'b0;
            // The head tag leaves before a same-cycle grant is appended.
            if (resp_valid && tag_q.size() > 0) begin
                sb_tag = tag_q.pop_front();
                exp_get_q.push_back({NUM_REQ'(1) << sb_tag, resp_cl_k, resp_cl_l});
                get_due = 1'b1;
            end
            sb_lane = -1;
            for (int i = 0; i < NUM_REQ; i++)
                if (req_valid[i] && req_ready[i]) sb_lane = i;
            if (sb_lane >= 0) begin
                exp_addr_q.push_back({bwt_base + {30'd0, req_addr_k[32*sb_lane+4 +: 28]},
                                      bwt_base + {30'd0, req_addr_l[32*sb_lane+4 +: 28]}});
                tag_q.push_back(TAG_W'(sb_lane));
                issue_due = 1'b1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        enable     = 1'b0;
        stall      = 1'b0;
        req_valid  = '0;
        resp_valid = 1'b0;
        resp_cl_k  = '0;
        resp_cl_l  = '0;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic set_lane(input int lane, input logic [31:0] ak, input logic [31:0] al);
        req_addr_k[32*lane +: 32] = ak;
        req_addr_l[32*lane +: 32] = al;
    endtask

    task automatic rand_resp();
        for (int w = 0; w < 16; w++) begin
            resp_cl_k[32*w +: 32] = $urandom();
            resp_cl_l[32*w +: 32] = $urandom();
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        req_valid = '1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_addr_k !== '0 || out_addr_l !== '0) begin
            failures++; $display("FAIL reset_out got v=%b k=%h l=%h exp 0", out_valid, out_addr_k, out_addr_l);
        end
        checks++;
        if (get_valid !== '0 || get_cl_k !== '0 || get_cl_l !== '0) begin
            failures++; $display("FAIL reset_get got gv=%b exp 0", get_valid);
        end
        checks++;
        if (outstanding !== '0 || idle !== 1'b1 || resp_error !== 1'b0) begin
            failures++; $display("FAIL reset_status got out=%0d idle=%b err=%b exp 0 1 0", outstanding, idle, resp_error);
        end
        checks++;
        if (req_ready !== '0) begin
            failures++; $display("FAIL reset_no_grant got %b exp 0000", req_ready);
        end
        tick();
        req_valid = '0;
    endtask

    task automatic test_single();
        logic [511:0] dk;
        bwt_base = 58'h1000;
        enable   = 1'b1;
        set_lane(0, 32'h1230, 32'h45F0);
        req_valid = 4'b0001;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0000) begin
            failures++; $display("FAIL single_idle_ready got %b exp 0000", req_ready);
        end
        tick();
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++; $display("FAIL single_ready got %b exp 0001", req_ready);
        end
        tick();
        req_valid  = '0;
        resp_valid = 1'b1;
        rand_resp();
        dk = resp_cl_k;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_addr_k !== 58'h1123 || out_addr_l !== 58'h145F || outstanding !== 5'd1) begin
            failures++;
            $display("FAIL single_issue got v=%b k=%h l=%h out=%0d exp 1 1123 145f 1",
                     out_valid, out_addr_k, out_addr_l, outstanding);
        end
        tick();
        resp_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (get_valid !== 4'b0001 || get_cl_k !== dk || outstanding !== 5'd0) begin
            failures++; $display("FAIL single_get got gv=%b out=%0d exp 0001 0", get_valid, outstanding);
        end
    endtask

    task automatic test_fill();
        apply_reset();
        bwt_base = 58'h3FF_FFFF_FFFF_FFF0;
        for (int i = 0; i < NUM_REQ; i++) set_lane(i, $urandom(), $urandom());
        enable = 1'b1;
        tick();
        req_valid = '1;
        for (int n = 0; n < MAX_OUT; n++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== 4'(1 << (n % NUM_REQ))) begin
                failures++; $display("FAIL fill_rr[%0d] got %b exp %b", n, req_ready, 4'(1 << (n % NUM_REQ)));
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (req_ready !== '0 || outstanding !== 5'd16) begin
            failures++; $display("FAIL fill_full got ready=%b out=%0d exp 0000 16", req_ready, outstanding);
        end
        tick();
        resp_valid = 1'b1;
        rand_resp();
        @(negedge clk);
        checks++;
        if (req_ready !== '0) begin
            failures++; $display("FAIL fill_no_bypass got %b exp 0000", req_ready);
        end
        tick();
        resp_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (get_valid !== 4'b0001 || outstanding !== 5'd15 || req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL fill_resume got gv=%b out=%0d ready=%b exp 0001 15 0001", get_valid, outstanding, req_ready);
        end
        tick();
        req_valid = '0;
        for (int n = 0; n < MAX_OUT; n++) begin
            resp_valid = 1'b1;
            rand_resp();
            tick();
        end
        resp_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (outstanding !== '0) begin
            failures++; $display("FAIL fill_drain got out=%0d exp 0", outstanding);
        end
    endtask

    task automatic test_order();
        logic [511:0] ak, al, bk, bl;
        tick();
        req_valid = 4'b0100;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0100) begin
            failures++; $display("FAIL order_grant2 got %b exp 0100", req_ready);
        end
        tick();
        req_valid = 4'b0010;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0010) begin
            failures++; $display("FAIL order_grant1 got %b exp 0010", req_ready);
        end
        tick();
        req_valid  = '0;
        resp_valid = 1'b1;
        rand_resp();
        ak = resp_cl_k; al = resp_cl_l;
        tick();
        rand_resp();
        bk = resp_cl_k; bl = resp_cl_l;
        @(negedge clk);
        checks++;
        if (get_valid !== 4'b0100 || get_cl_k !== ak || get_cl_l !== al) begin
            failures++; $display("FAIL order_first got gv=%b exp 0100 with A", get_valid);
        end
        tick();
        resp_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (get_valid !== 4'b0010 || get_cl_k !== bk || get_cl_l !== bl || outstanding !== '0) begin
            failures++; $display("FAIL order_second got gv=%b out=%0d exp 0010 0 with B", get_valid, outstanding);
        end
    endtask

    task automatic test_stall();
        tick();
        req_valid = '1;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0100) begin
            failures++; $display("FAIL stall_pre got %b exp 0100", req_ready);
        end
        tick();
        stall = 1'b1;
        for (int c = 0; c < 5; c++) begin
            resp_valid = (c == 2);
            if (c == 2) rand_resp();
            @(negedge clk);
            checks++;
            if (req_ready !== '0) begin
                failures++; $display("FAIL stall_ready[%0d] got %b exp 0000", c, req_ready);
            end
            if (c > 0) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    failures++; $display("FAIL stall_out_valid[%0d] got %b exp 0", c, out_valid);
                end
            end
            if (c == 3) begin
                checks++;
                if (get_valid !== 4'b0100 || outstanding !== '0) begin
                    failures++; $display("FAIL stall_get got gv=%b out=%0d exp 0100 0", get_valid, outstanding);
                end
            end
            tick();
        end
        stall      = 1'b0;
        resp_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b1000) begin
            failures++; $display("FAIL stall_release got %b exp 1000", req_ready);
        end
        tick();
        req_valid  = '0;
        resp_valid = 1'b1;
        rand_resp();
        tick();
        resp_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (get_valid !== 4'b1000) begin
            failures++; $display("FAIL stall_post_get got %b exp 1000", get_valid);
        end
    endtask

    task automatic test_drain();
        tick();
        req_valid = '1;
        for (int n = 0; n < 3; n++) begin
            if (n == 2) enable = 1'b0;
            @(negedge clk);
            checks++;
            if (req_ready !== 4'(1 << n)) begin
                failures++; $display("FAIL drain_grant[%0d] got %b exp %b", n, req_ready, 4'(1 << n));
            end
            tick();
        end
        enable = 1'b1;
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== '0 || idle !== 1'b0 || outstanding !== 5'd3) begin
                failures++;
                $display("FAIL drain_hold[%0d] got ready=%b idle=%b out=%0d exp 0000 0 3", n, req_ready, idle, outstanding);
            end
            tick();
        end
        enable    = 1'b0;
        req_valid = '0;
        for (int n = 0; n < 3; n++) begin
            resp_valid = 1'b1;
            rand_resp();
            tick();
        end
        resp_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (outstanding !== '0 || idle !== 1'b0) begin
            failures++; $display("FAIL drain_zero got out=%0d idle=%b exp 0 0", outstanding, idle);
        end
        tick();
        @(negedge clk);
        checks++;
        if (idle !== 1'b1) begin
            failures++; $display("FAIL drain_idle got %b exp 1", idle);
        end
    endtask

    task automatic test_error_reset();
        tick();
        resp_valid = 1'b1;
        rand_resp();
        tick();
        resp_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (resp_error !== 1'b1 || get_valid !== '0) begin
            failures++; $display("FAIL err_set got err=%b gv=%b exp 1 0000", resp_error, get_valid);
        end
        repeat (3) tick();
        @(negedge clk);
        checks++;
        if (resp_error !== 1'b1) begin
            failures++; $display("FAIL err_sticky got %b exp 1", resp_error);
        end
        tick();
        enable = 1'b1;
        tick();
        req_valid = '1;
        tick();
        tick();
        checks++;
        if (outstanding !== 5'd2 || out_valid !== 1'b1) begin
            failures++; $display("FAIL burst_pre got out=%0d v=%b exp 2 1", outstanding, out_valid);
        end
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if (outstanding !== '0 || out_valid !== 1'b0 || resp_error !== 1'b0 || idle !== 1'b1) begin
            failures++;
            $display("FAIL async_reset got out=%0d v=%b err=%b idle=%b exp 0 0 0 1", outstanding, out_valid, resp_error, idle);
        end
        drive_idle();
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (outstanding !== '0 || get_valid !== '0) begin
            failures++; $display("FAIL post_reset got out=%0d gv=%b exp 0 0000", outstanding, get_valid);
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        bwt_base   = '0;
        req_addr_k = '0;
        req_addr_l = '0;
        drive_idle();
        apply_reset();
        test_reset();
        test_single();
        test_fill();
        test_order();
        test_stall();
        test_drain();
        test_error_reset();
        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bwt_req_arbiter.md
Name: bwt_req_arbiter

Overview:
Shares the single paired BWT occurrence-table read path (k/l cache-line pair per request) among NUM_REQ independent SMEM pipeline lanes in the 200 MHz domain. It arbitrates lane requests round-robin and forms line addresses from the BWT base. It tracks outstanding pairs in an in-order tag FIFO and routes each returning k/l cache-line pair back to the lane that issued it. It sits between the lane array and the request/response aFIFOs of the core; an enable/drain state machine lets the core stop issue cleanly before output or reset of a batch.

Parameters:
NUM_REQ, 4, number of requesting lanes (2..16)
TAG_W, 2, lane-index width, ceil(log2(NUM_REQ))
MAX_OUT, 16, maximum outstanding request pairs; tag FIFO depth, power of two
CNT_W, 5, outstanding counter width, log2(MAX_OUT)+1

Ports:
CLK_200M  in  1  core clock; all logic on rising edge
reset_n  in  1  asynchronous active-low reset
enable  in  1  level; 1 = grant new requests
stall  in  1  downstream almost-full; blocks grants
bwt_base  in  58  cache-line base address of BWT table
req_valid  in  NUM_REQ  per-lane request valid
req_addr_k  in  NUM_REQ*32  per-lane k byte address, lane i at [32i+31:32i]
req_addr_l  in  NUM_REQ*32  per-lane l byte address, same packing
req_ready  out  NUM_REQ  one-hot grant, combinational
out_valid  out  1  request pair valid, to request FIFO write enable
out_addr_k  out  58  k cache-line address
out_addr_l  out  58  l cache-line address
resp_valid  in  1  response pair valid (both_valid)
resp_cl_k  in  512  k cache line
resp_cl_l  in  512  l cache line
get_valid  out  NUM_REQ  one-hot response delivery strobe
get_cl_k  out  512  k line, broadcast to all lanes
get_cl_l  out  512  l line, broadcast to all lanes
outstanding  out  CNT_W  pairs issued but not yet returned
idle  out  1  1 in IDLE state
resp_error  out  1  sticky; response arrived with no outstanding tag

Behaviour:
- Reset (async assert, sync release): state=IDLE, RR pointer=0, outstanding=0, tag FIFO empty, out_valid=0, out_addr_k/l=0, get_valid=0, get_cl_k/l=0, resp_error=0, idle=1.
- States:
  - IDLE: no grants. Goes to RUN when enable=1.
  - RUN: grants allowed. Goes to DRAIN when enable=0.
  - DRAIN: no grants; enable is ignored. Goes to IDLE when outstanding==0 and no pop is pending that cycle.
- can_grant = (state==RUN) & !stall & (outstanding<MAX_OUT).
- Arbitration: search lanes ptr, ptr+1, ... mod NUM_REQ; the first lane with req_valid wins. req_ready is one-hot to that lane only when can_grant; otherwise all zero.
- A transfer occurs when req_valid[i] & req_ready[i].
- On a grant, ptr <= (winner+1) mod NUM_REQ. With no grant, ptr is held.
- Issue latency 1 cycle: the cycle after a grant, out_valid=1 with:
  - out_addr_k = bwt_base + zero-extended req_addr_k[31:4], mod 2^58.
  - out_addr_l = bwt_base + zero-extended req_addr_l[31:4], mod 2^58.
- With no grant, out_valid=0 and out_addr_k/l hold their previous values.
- A grant pushes the winner index into the tag FIFO in the same cycle.
- Responses are in order. On resp_valid with FIFO non-empty, pop the head tag. Next cycle: get_valid=onehot(tag), get_cl_k/l = registered resp_cl_k/l. get_valid otherwise 0; get_cl_* hold.
- outstanding: +1 on push, -1 on pop; unchanged on simultaneous push and pop. Always equals FIFO occupancy.
- Full FIFO: no grant, even if a pop occurs in the same cycle. The freed slot is usable the next cycle (no full-bypass).
- Empty FIFO with resp_valid: drop the response, get_valid stays 0, resp_error<=1 until reset.
- A stall asserted mid-stream blocks only new grants; responses are still accepted and delivered.
- Pointers wrap modulo MAX_OUT.
- Reset mid-operation: everything clears immediately and in-flight tags are discarded. The core must reset the aFIFOs simultaneously.

Test Plan:
1. Reset, enable=1, lane0 only, addr_k=0x1230, addr_l=0x45F0, bwt_base=0x1000 -> one cycle later out_valid=1, out_addr_k=0x1123, out_addr_l=0x145F; outstanding=1.
2. All 4 lanes valid continuously, no stall, no responses -> grants 0,1,2,3,0,... until outstanding=16, then req_ready=0; one response pops tag 0 -> get_valid=0001 next cycle; grant resumes the following cycle.
3. Grant lanes 2 then 1, return two responses with distinct data A,B -> get_valid=0100 with A, then 0010 with B; outstanding returns to 0.
4. stall=1 for 5 cycles with requests pending -> req_ready=0 and out_valid=0 throughout; a response during stall is still delivered.
5. 3 outstanding, drop enable -> state DRAIN, no grants even if enable reasserts; after 3 responses idle=1 one cycle after outstanding reaches 0.
6. resp_valid with outstanding=0 -> resp_error=1, get_valid=0; stays 1 until reset_n pulse; async reset mid-burst clears outstanding and out_valid without a clock edge.
